// File: rtl/multichannel_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : multichannel_delay_line
// Description : Delay line for gp_nr_channels time-interleaved sample
//               streams. Each channel can be delayed by up to gp_nr_stages
//               of its own samples. The delay is selected at run time.
//               The block also provides a synchronous clear, a channel tag
//               and a fill flag that follows the selected depth.
//
// Ports       : i_clk        rising-edge clock
//               i_rst_an     asynchronous active-low reset
//               i_ena        sample enable (one interleaved sample per cycle)
//               i_clr        synchronous clear, overrides i_ena
//               i_delay      per-channel delay D (0 acts as 1, >N acts as N)
//               i_data       interleaved input sample (signed)
//               o_data       delayed sample of channel o_ch
//               o_ch         channel index of o_data
//               o_shift_done line filled to the selected depth
//
// Options     : MULTICHANNEL_DELAY_LINE_OREG_EN - registers all outputs
//               (adds one cycle of latency)
//
// Revision    : 1.0 - initial release
// ============================================================================
module multichannel_delay_line #(
    parameter  int gp_data_width  = 8,
    parameter  int gp_nr_stages   = 4,
    parameter  int gp_nr_channels = 2,
    localparam int c_ch_width     = (gp_nr_channels > 1) ? $clog2(gp_nr_channels) : 1,
    localparam int c_dly_width    = $clog2(gp_nr_stages + 1),
    localparam int c_cnt_width    = $clog2(gp_nr_stages * gp_nr_channels + 1)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_an,
    input  logic                            i_ena,
    input  logic                            i_clr,
    input  logic        [c_dly_width-1:0]   i_delay,
    input  logic signed [gp_data_width-1:0] i_data,
    output logic signed [gp_data_width-1:0] o_data,
    output logic        [c_ch_width-1:0]    o_ch,
    output logic                            o_shift_done
);

    localparam int c_len = gp_nr_stages * gp_nr_channels;

    // r_sr[p] holds the sample that was accepted p enabled cycles ago.
    logic signed [gp_data_width-1:0] r_sr [1:c_len];
    logic        [c_ch_width-1:0]    r_ch;
    logic        [c_cnt_width-1:0]   r_cnt;

    logic        [c_dly_width-1:0]   w_deff;
    logic        [c_cnt_width-1:0]   w_sel;
    logic signed [gp_data_width-1:0] w_data;
    logic                            w_done;

    // ------------------------------------------------------------------------
    // Sample storage
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int p = 1; p <= c_len; p++) r_sr[p] <= '0;
        end else if (i_clr) begin
            for (int p = 1; p <= c_len; p++) r_sr[p] <= '0;
        end else if (i_ena) begin
            r_sr[1] <= i_data;
            for (int p = 2; p <= c_len; p++) r_sr[p] <= r_sr[p-1];
        end
    end

    // ------------------------------------------------------------------------
    // Fill counter. It saturates at the line length so that o_shift_done
    // stays valid for any later delay selection.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_ena && (r_cnt != c_cnt_width'(c_len))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Write-channel pointer
    // ------------------------------------------------------------------------
    generate
        if (gp_nr_channels > 1) begin : g_ch_multi
            always_ff @(posedge i_clk or negedge i_rst_an) begin
                if (!i_rst_an) begin
                    r_ch <= '0;
                end else if (i_clr) begin
                    r_ch <= '0;
                end else if (i_ena) begin
                    if (r_ch == c_ch_width'(gp_nr_channels - 1)) r_ch <= '0;
                    else                                         r_ch <= r_ch + 1'b1;
                end
            end
        end else begin : g_ch_single
            assign r_ch = '0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Delay clamp and tap select. Tap Deff*C holds the current channel's
    // sample from Deff of its own samples ago.
    // ------------------------------------------------------------------------
    always_comb begin
        w_deff = i_delay;
        if (i_delay == '0)
            w_deff = c_dly_width'(1);
        else if (i_delay > c_dly_width'(gp_nr_stages))
            w_deff = c_dly_width'(gp_nr_stages);
    end

    always_comb begin
        w_data = '0;
        w_sel  = '0;
        for (int d = 1; d <= gp_nr_stages; d++) begin
            if (w_deff == c_dly_width'(d)) begin
                w_data = r_sr[d * gp_nr_channels];
                w_sel  = c_cnt_width'(d * gp_nr_channels);
            end
        end
    end

    assign w_done = (r_cnt >= w_sel);

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
`ifdef MULTICHANNEL_DELAY_LINE_OREG_EN
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            o_data       <= '0;
            o_ch         <= '0;
            o_shift_done <= 1'b0;
        end else if (i_clr) begin
            o_data       <= '0;
            o_ch         <= '0;
            o_shift_done <= 1'b0;
        end else begin
            o_data       <= w_data;
            o_ch         <= r_ch;
            o_shift_done <= w_done;
        end
    end
`else
    assign o_data       = w_data;
    assign o_ch         = r_ch;
    assign o_shift_done = w_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multichannel_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_multichannel_delay_line
// Description : Directed self-checking bench. It drives two instances in
//               parallel: a single-channel one (C=1, N=4) and a two-channel
//               one (C=2, N=4). Both instances share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multichannel_delay_line;

    logic              clk;
    logic              rst_an;
    logic              ena;
    logic              clr;
    logic [2:0]        delay;
    logic signed [7:0] data;

    logic signed [7:0] c1_data;
    logic [0:0]        c1_ch;
    logic              c1_done;
    logic signed [7:0] c2_data;
    logic [0:0]        c2_ch;
    logic              c2_done;

    int n_chk;
    int n_err;

    multichannel_delay_line #(
        .gp_data_width (8),
        .gp_nr_stages  (4),
        .gp_nr_channels(1)
    ) u_dut_c1 (
        .i_clk       (clk),
        .i_rst_an    (rst_an),
        .i_ena       (ena),
        .i_clr       (clr),
        .i_delay     (delay),
        .i_data      (data),
        .o_data      (c1_data),
        .o_ch        (c1_ch),
        .o_shift_done(c1_done)
    );

    multichannel_delay_line #(
        .gp_data_width (8),
        .gp_nr_stages  (4),
        .gp_nr_channels(2)
    ) u_dut_c2 (
        .i_clk       (clk),
        .i_rst_an    (rst_an),
        .i_ena       (ena),
        .i_clr       (clr),
        .i_delay     (delay),
        .i_data      (data),
        .o_data      (c2_data),
        .o_ch        (c2_ch),
        .o_shift_done(c2_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Lets the combinational outputs settle. With registered outputs it
    // waits one more cycle so that the output registers catch up.
    task automatic settle();
        #1;
`ifdef MULTICHANNEL_DELAY_LINE_OREG_EN
        @(posedge clk);
        #1;
`endif
    endtask

    // Accepts one sample, idles again and then settles the outputs.
    task automatic accept(input int value);
        data = 8'(value);
        ena  = 1'b1;
        @(posedge clk);
        #1;
        ena  = 1'b0;
        settle();
    endtask

    task automatic clear();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        settle();
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        rst_an = 1'b0;
        ena    = 1'b0;
        clr    = 1'b0;
        delay  = 3'd1;
        data   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_an = 1'b1;
        settle();
        check("reset_c2_data", int'(c2_data), 0);
        check("reset_c2_ch",   int'(c2_ch),   0);
        check("reset_c2_done", int'(c2_done), 0);

        // Assert reset asynchronously in the middle of a stream.
        data = 8'd5; ena = 1'b1; @(posedge clk); #1;
        data = 8'd6;             @(posedge clk); #1;
        data = 8'd7;             @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_c1_data", int'(c1_data), 7);
        #2;
        rst_an = 1'b0;
        #1;
        check("async_rst_c1_data", int'(c1_data), 0);
        check("async_rst_c1_done", int'(c1_done), 0);
        check("async_rst_c2_ch",   int'(c2_ch),   0);
        ena = 1'b0;
        @(posedge clk); #1;
        rst_an = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_c1_data", int'(c1_data), 0);
        check("post_rst_c2_ch",   int'(c2_ch),   0);
        check("post_rst_c2_done", int'(c2_done), 0);

        // Single-channel instance, delay 4, fed with 1..6.
        delay = 3'd4;
        accept(1); accept(2); accept(3);
        check("sc_done_after3", int'(c1_done), 0);
        accept(4);
        check("sc_done_after4", int'(c1_done), 1);
        check("sc_data_after4", int'(c1_data), 1);
        accept(5);
        check("sc_data_after5", int'(c1_data), 2);
        accept(6);
        check("sc_data_after6", int'(c1_data), 3);

        // Changing the delay mid-stream and clamping the delay value.
        clear();
        accept(1); accept(2); accept(3); accept(4);
        check("dly4_data", int'(c1_data), 1);
        delay = 3'd2; settle();
        check("dly2_data", int'(c1_data), 3);
        check("dly2_done", int'(c1_done), 1);
        delay = 3'd0; settle();
        check("dly0_data", int'(c1_data), 4);
        delay = 3'd7; settle();
        check("dly7_data", int'(c1_data), 1);
        check("dly7_done", int'(c1_done), 1);
        clear();
        check("clr_c1_data", int'(c1_data), 0);
        accept(9);
        delay = 3'd3; settle();
        check("refill_dly3_done", int'(c1_done), 0);
        delay = 3'd1; settle();
        check("refill_dly1_done", int'(c1_done), 1);
        check("refill_dly1_data", int'(c1_data), 9);

        // Enable gating: five idle cycles must leave all state unchanged.
        repeat (5) @(posedge clk);
        #1;
        check("gate_c1_data", int'(c1_data), 9);
        check("gate_c2_ch",   int'(c2_ch),   1);
        check("gate_c2_done", int'(c2_done), 0);

        // Interleaved instance, delay 2.
        clear();
        delay = 3'd2;
        accept(10); accept(20); accept(11);
        check("il_done_after3", int'(c2_done), 0);
        accept(21);
        check("il_ch_after4",   int'(c2_ch),   0);
        check("il_data_after4", int'(c2_data), 10);
        check("il_done_after4", int'(c2_done), 1);
        accept(12);
        check("il_ch_after5",   int'(c2_ch),   1);
        check("il_data_after5", int'(c2_data), 20);
        accept(22);
        check("il_data_after6", int'(c2_data), 11);

        // The fill counter saturates and never wraps (line length is 8).
        delay = 3'd4;
        for (int i = 0; i < 17; i++) accept(30 + i);
        check("sat_c2_done", int'(c2_done), 1);
        check("sat_c2_data", int'(c2_data), 39);

        // Clear takes priority over a simultaneous enable.
        data = 8'd99;
        ena  = 1'b1;
        clr  = 1'b1;
        @(posedge clk);
        #1;
        ena  = 1'b0;
        clr  = 1'b0;
        settle();
        check("clrpri_c2_data", int'(c2_data), 0);
        check("clrpri_c2_ch",   int'(c2_ch),   0);
        check("clrpri_c2_done", int'(c2_done), 0);
        check("clrpri_c1_data", int'(c1_data), 0);
        accept(50);
        check("clrpri_next_ch",   int'(c2_ch),   1);
        check("clrpri_next_done", int'(c2_done), 0);
        accept(60);
        check("clrpri_next2_ch",  int'(c2_ch),   0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
